tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Parametrised beep-pattern generator for the answering machine's audible prompts (ring-back, record-start beep, error triple-beep, message-waiting cadence). It takes a per-request tone half-period, ON/OFF durations and a burst count, then emits a square-wave `beep` in bursts separated by silent gaps. A start/busy/done handshake lets the control FSM chain prompts, and a stop input aborts a pattern. It drives the buzzer pin directly and replaces fixed-duration, fixed-frequency beep generation.

## Interface

Parameters:
- `HP_W`, 24, width of tone half-period (in clk cycles)
- `DUR_W`, 16, width of ON/OFF durations (in time units)
- `REP_W`, 8, width of burst count
- `UNIT_CYCLES`, 100000, clk cycles per time unit (1 ms at 100 MHz); must be ≥1

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `half_period`  in  HP_W  tone half-period in clk cycles; latched on accepted start
- `on_units`  in  DUR_W  burst length in units; latched
- `off_units`  in  DUR_W  gap length in units; latched
- `repeats`  in  REP_W  number of bursts; latched
- `stop`  in  1  synchronous abort
- `beep`  out  1  registered square-wave output
- `busy`  out  1  registered; high while a pattern runs
- `done`  out  1  registered one-cycle pulse on normal completion

## Operation

- States: IDLE, ON, OFF.
- IDLE: `beep`=0, `busy`=0. On `start`=1 and `stop`=0, latch all config inputs.
  - If the latched `repeats`, `on_units` or `half_period` is 0, pulse `done` next cycle and stay IDLE (degenerate request). `beep` and `busy` never assert.
  - Otherwise go to ON with burst counter = `repeats`.
- ON: unit prescaler counts 0..UNIT_CYCLES-1 and the unit counter counts `on_units`. Both restart at every phase entry, so ON lasts exactly `on_units`×UNIT_CYCLES cycles.
  - `beep`=1 in the first ON cycle. It toggles after every `half_period` ON cycles, and the tone counter restarts at each ON entry.
  - At ON end: decrement the burst counter. If bursts remain and `off_units`>0, go to OFF. If bursts remain and `off_units`=0, re-enter ON directly. If none remain, go to IDLE, clear `busy` and pulse `done`.
- OFF: `beep`=0 for exactly `off_units`×UNIT_CYCLES cycles, then go to ON.
- The final burst is never followed by OFF.
- `start` while `busy`=1 is ignored. Config input changes while busy have no effect.
- `stop`=1 in any state: next cycle IDLE, `beep`=0, `busy`=0, `done`=0. `stop` wins over a simultaneous `start` and over a simultaneous normal completion (no `done`).
- `rst`=1 has priority over everything. Next cycle: IDLE, `beep`=0, `busy`=0, `done`=0, all counters 0.
- Counter widths: prescaler ⌈log2(UNIT_CYCLES)⌉ (min 1), unit counter DUR_W, tone counter HP_W, burst counter REP_W. No counter wraps in normal operation.

## Timing

- Start accepted at cycle 0 → cycle 1: state ON, `beep`=1, `busy`=1.
- Let N = `on_units`×UNIT_CYCLES and G = `off_units`×UNIT_CYCLES. Burst k (1-based) occupies cycles 1+(k-1)(N+G) .. k·N+(k-1)G.
- `done`=1 and `busy`=0 in cycle R·N+(R-1)·G+1, where R=`repeats`. `done` is high for exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high, so back-to-back patterns have zero idle gap.
- Degenerate request: `done` at cycle 1, `busy` stays 0.
- `stop` or `rst` at cycle t → all outputs 0 at cycle t+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

UNIT_CYCLES=10 for all scenarios.

- `half_period`=2, `on_units`=3, `off_units`=2, `repeats`=2 → `beep` high on cycles 1-2, low 3-4, and so on through cycle 30; low 31-50; same pattern 51-80; `done` only at cycle 81; `busy` high exactly cycles 1-80.
- `repeats`=0 (other fields nonzero) → `done` at cycle 1; `beep` and `busy` stay 0.
- Same config as the first scenario, `stop` at cycle 40 (inside OFF) → cycle 41 all outputs 0; no `done`. Then `start` at cycle 45 → `beep` high at cycle 46.
- `start` pulsed again at cycle 10 with `repeats`=5, `half_period`=1 during a running pattern → waveform and `done` cycle identical to the undisturbed run.
- `rst` asserted at cycle 15 mid-ON → cycle 16 `beep`=`busy`=`done`=0. A fresh `start` after release behaves as in the first scenario.
- `half_period`=7, `on_units`=3, `off_units`=0, `repeats`=3 → `busy` high cycles 1-90. `beep` restarts high at cycles 1, 31 and 61, and toggles at 8, 15, 22, 29 within each burst (offset per burst). `done` at cycle 91.

Source files
------------

// File: rtl/tone_if.sv
// tone_if: request/response bundle between the prompt controller and the
// tone_sequencer buzzer engine.
//   master: drives start, half_period, on_units, off_units, repeats, stop;
//           observes beep, busy, done.
//   slave : the sequencer side (mirror image of master).
interface tone_if #(
  parameter int HP_W  = 24,
  parameter int DUR_W = 16,
  parameter int REP_W = 8
);
  logic             start;
  logic [HP_W-1:0]  half_period;
  logic [DUR_W-1:0] on_units;
  logic [DUR_W-1:0] off_units;
  logic [REP_W-1:0] repeats;
  logic             stop;
  logic             beep;
  logic             busy;
  logic             done;

  modport master (
    output start, half_period, on_units, off_units, repeats, stop,
    input  beep, busy, done
  );

  modport slave (
    input  start, half_period, on_units, off_units, repeats, stop,
    output beep, busy, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: beep-pattern generator for audible prompts.
// Emits `repeats` bursts of a square wave (half-period `half_period` clk
// cycles), each burst `on_units` time units long, separated by `off_units`
// silent units. One time unit is UNIT_CYCLES clk cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - tone_if.slave: start/config/stop in, beep/busy/done out
//          (all outputs registered)
module tone_sequencer #(
  parameter int HP_W        = 24,
  parameter int DUR_W       = 16,
  parameter int REP_W       = 8,
  parameter int UNIT_CYCLES = 100000
) (
  input  logic   clk,
  input  logic   rst,
  tone_if.slave  bus
);

  localparam int PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [DUR_W-1:0]  on_q, on_d;
  logic [DUR_W-1:0]  off_q, off_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUR_W-1:0]  unit_q, unit_d;
  logic [HP_W-1:0]   tone_q, tone_d;
  logic              beep_q, beep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              unit_tick;
  logic              phase_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      on_q    <= '0;
      off_q   <= '0;
      rep_q   <= '0;
      pre_q   <= '0;
      unit_q  <= '0;
      tone_q  <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      on_q    <= on_d;
      off_q   <= off_d;
      rep_q   <= rep_d;
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    on_d    = on_q;
    off_d   = off_q;
    rep_d   = rep_q;
    pre_d   = pre_q;
    unit_d  = unit_q;
    tone_d  = tone_q;
    beep_d  = beep_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Last cycle of the current ON/OFF phase: final prescaler count of the
    // final unit of that phase.
    unit_tick  = (pre_q == PRE_LAST);
    phase_last = unit_tick &&
                 (unit_q == (((state_q == S_ON) ? on_q : off_q) - DUR_W'(1)));

    case (state_q)
      S_IDLE: begin
        beep_d = 1'b0;
        busy_d = 1'b0;
        if (bus.start && !bus.stop) begin
          hp_d  = bus.half_period;
          on_d  = bus.on_units;
          off_d = bus.off_units;
          if (bus.repeats == '0 || bus.on_units == '0 || bus.half_period == '0) begin
            // Nothing audible to play: acknowledge immediately.
            done_d = 1'b1;
          end else begin
            state_d = S_ON;
            rep_d   = bus.repeats;
            busy_d  = 1'b1;
            beep_d  = 1'b1;
            pre_d   = '0;
            unit_d  = '0;
            tone_d  = '0;
          end
        end
      end

      S_ON: begin
        pre_d  = unit_tick ? '0 : pre_q + PRE_W'(1);
        unit_d = unit_tick ? unit_q + DUR_W'(1) : unit_q;
        if (tone_q == hp_q - HP_W'(1)) begin
          tone_d = '0;
          beep_d = ~beep_q;
        end else begin
          tone_d = tone_q + HP_W'(1);
        end
        if (phase_last) begin
          rep_d  = rep_q - REP_W'(1);
          pre_d  = '0;
          unit_d = '0;
          tone_d = '0;
          if (rep_q == REP_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            beep_d  = 1'b0;
            done_d  = 1'b1;
          end else if (off_q != '0) begin
            state_d = S_OFF;
            beep_d  = 1'b0;
          end else begin
            // Zero-length gap: next burst starts straight away, tone phase reset.
            beep_d = 1'b1;
          end
        end
      end

      S_OFF: begin
        pre_d  = unit_tick ? '0 : pre_q + PRE_W'(1);
        unit_d = unit_tick ? unit_q + DUR_W'(1) : unit_q;
        beep_d = 1'b0;
        if (phase_last) begin
          state_d = S_ON;
          pre_d   = '0;
          unit_d  = '0;
          tone_d  = '0;
          beep_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        beep_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides any start acceptance or completion in the same cycle.
    if (bus.stop) begin
      state_d = S_IDLE;
      rep_d   = '0;
      pre_d   = '0;
      unit_d  = '0;
      tone_d  = '0;
      beep_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign bus.beep = beep_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer with UNIT_CYCLES=10.
// Stimulus pushes the expected {beep,busy,done} of every cycle; the monitor
// pops one entry per cycle at the falling edge and compares it.
module tb_tone_sequencer;

  localparam int UC = 10;

  logic clk;
  logic rst;

  tone_if #(.HP_W(24), .DUR_W(16), .REP_W(8)) bus ();

  tone_sequencer #(
    .HP_W(24), .DUR_W(16), .REP_W(8), .UNIT_CYCLES(UC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    int         rel;
    logic [2:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks;
  int  errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {beep,busy,done} at cycle `rel` after a start accepted at rel 0,
  // straight from the burst/gap timing formulas.
  function automatic logic [2:0] ref_out(input int rel, input int hp,
                                         input int on, input int off, input int rep);
    int n;
    int g;
    int total;
    int pos;
    if (rep == 0 || on == 0 || hp == 0) return (rel == 1) ? 3'b001 : 3'b000;
    n     = on * UC;
    g     = off * UC;
    total = rep * n + (rep - 1) * g;
    if (rel >= 1 && rel <= total) begin
      pos = (rel - 1) % (n + g);
      if (pos < n) return {((pos / hp) % 2 == 0), 1'b1, 1'b0};
      return 3'b010;
    end
    if (rel == total + 1) return 3'b001;
    return 3'b000;
  endfunction

  // Monitor: one comparison per pushed expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [2:0] got;
      e   = sb.pop_front();
      got = {bus.beep, bus.busy, bus.done};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL scen%0d cyc%0d {beep,busy,done} got %b want %b",
                 e.id, e.rel, got, e.exp);
      end
    end
  end

  // One pattern run. rel 0 is the cycle `start` is driven.
  //   abort_at  : cycle where stop (or rst if use_rst) is pulsed, -1 = none
  //   disturb_at: cycle where a second start with other config is pulsed
  //   exp0_done : expected done at rel 0 (back-to-back after a completion)
  task automatic run(input int id, input int hp, input int on, input int off,
                     input int rep, input int abort_at, input bit use_rst,
                     input int disturb_at, input int len, input bit exp0_done);
    for (int rel = 0; rel <= len; rel++) begin
      sb_t e;
      @(posedge clk);
      #1;
      e.id  = id;
      e.rel = rel;
      if (rel == 0)
        e.exp = {2'b00, exp0_done};
      else if (abort_at >= 0 && rel > abort_at)
        e.exp = 3'b000;
      else
        e.exp = ref_out(rel, hp, on, off, rep);
      sb.push_back(e);

      bus.start = (rel == 0) || (rel == disturb_at);
      if (disturb_at >= 0 && rel >= disturb_at) begin
        bus.half_period = 24'd1;
        bus.on_units    = 16'd1;
        bus.off_units   = 16'd7;
        bus.repeats     = 8'd5;
      end else begin
        bus.half_period = hp[23:0];
        bus.on_units    = on[15:0];
        bus.off_units   = off[15:0];
        bus.repeats     = rep[7:0];
      end
      bus.stop = !use_rst && (rel == abort_at);
      rst      = use_rst && (rel == abort_at);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.half_period = '0;
    bus.on_units    = '0;
    bus.off_units   = '0;
    bus.repeats     = '0;

    repeat (3) @(posedge clk);
    #1;
    e.id = 0; e.rel = 0; e.exp = 3'b000;
    sb.push_back(e);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic two-burst pattern, done at 81.
    run(1, 2, 3, 2, 2, -1, 1'b0, -1, 85, 1'b0);
    // Degenerate requests: zero repeats, zero half-period, zero on_units.
    run(2, 2, 3, 2, 0, -1, 1'b0, -1, 4, 1'b0);
    run(3, 0, 3, 2, 2, -1, 1'b0, -1, 4, 1'b0);
    run(4, 2, 0, 2, 2, -1, 1'b0, -1, 4, 1'b0);
    // Stop inside OFF at 40, restart at 45 (new run's rel 0), run to its
    // last busy cycle, then a back-to-back start in the done cycle.
    run(5, 2, 3, 2, 2, 40, 1'b0, -1, 44, 1'b0);
    run(6, 2, 3, 2, 2, -1, 1'b0, -1, 80, 1'b0);
    run(7, 7, 3, 0, 3, -1, 1'b0, -1, 95, 1'b1);
    // Second start with different config while busy must be ignored.
    run(8, 2, 3, 2, 2, -1, 1'b0, 10, 85, 1'b0);
    // Reset mid-ON, then a fresh pattern.
    run(9, 2, 3, 2, 2, 15, 1'b1, -1, 20, 1'b0);
    run(10, 2, 3, 2, 2, -1, 1'b0, -1, 85, 1'b0);
    // Stop in the final ON cycle suppresses done.
    run(11, 2, 3, 2, 2, 80, 1'b0, -1, 85, 1'b0);
    // Stop together with start: request ignored.
    run(12, 2, 3, 2, 2, 0, 1'b0, -1, 5, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
